// File: rtl/ripple_accumulator.sv
// ============================================================================
// Module   : ripple_accumulator (with ripple_adder_prim)
// Brief    : Sums COUNT unsigned operands per frame over valid/ready streams,
//            with a sticky per-frame carry-out flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_adder_prim #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  input  logic             i_carry,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = i_carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = i_data0[i] ^ i_data1[i] ^ w_c[i];
    assign w_c[i+1] = (i_data0[i] & i_data1[i]) | (w_c[i] & (i_data0[i] ^ i_data1[i]));
  end

  assign co = w_c[WIDTH];

endmodule

module ripple_accumulator #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CNT_W = $clog2(COUNT + 1);

  localparam logic [0:0]       c_st_acc = 1'b0;
  localparam logic [0:0]       c_st_out = 1'b1;
  localparam logic [CNT_W-1:0] c_last   = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [0:0]       r_state;

  logic [WIDTH-1:0] w_sum;
  logic             w_co;
  logic             w_in_xfer;
  logic             w_out_xfer;

  ripple_adder_prim #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_data0 (r_acc),
    .i_data1 (i_data),
    .i_carry (1'b0),
    .sum     (w_sum),
    .co      (w_co)
  );

  // Handshakes decode from state only, so no input-to-output combinational path.
  assign o_ready    = (r_state == c_st_acc);
  assign o_valid    = (r_state == c_st_out);
  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = o_valid && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_state <= c_st_acc;
    end else if (i_clear) begin
      // Abort wins over both handshakes that might coincide with it.
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_state <= c_st_acc;
    end else if (w_in_xfer) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | w_co;
      if (r_cnt == c_last) begin
        r_cnt   <= '0;
        r_state <= c_st_out;
      end else begin
        r_cnt <= r_cnt + c_one;
      end
    end else if (w_out_xfer) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_state <= c_st_acc;
    end
  end

  assign o_sum   = r_acc;
  assign o_carry = r_ovf;

endmodule

`default_nettype wire
